// File: rtl/id_ex_register_if.sv
// Decode-to-execute beat: valid/ready handshake plus the decoded instruction fields.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface id_ex_register_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [12:0]     ctrl;

  modport master (
    output valid, opcode, rd, rs1, rs2, funct3, funct7,
           pc, rs1_data, rs2_data, imm, ctrl,
    input  ready
  );

  modport slave (
    input  valid, opcode, rd, rs1, rs2, funct3, funct7,
           pc, rs1_data, rs2_data, imm, ctrl,
    output ready
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection, flush and gated control outputs.
// Optional stall counter is enabled by defining ID_EX_STALL_COUNT_EN.
module id_ex_register #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  id_ex_register_if.slave     in_bus,
  id_ex_register_if.master    out_bus,
  output logic                out_regfile_wr_en,
  output logic                out_is_branch,
  output logic                out_is_jal,
  output logic                out_is_jalr,
  output logic                out_mem_rd_en,
  output logic                out_mem_wr_en,
  output logic [3:0]          out_alu_select
`ifdef ID_EX_STALL_COUNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_SELECT_NOP = 4'hF;

  // ctrl bit positions; bit 12 is reserved and passes straight through
  localparam int C_WR   = 11;
  localparam int C_BR   = 10;
  localparam int C_JAL  = 9;
  localparam int C_JALR = 8;
  localparam int C_MDS  = 7;
  localparam int C_MRD  = 6;
  localparam int C_MWR  = 5;
  localparam int C_RSB  = 4;

  logic            valid_q;
  logic [6:0]      opcode_q;
  logic [4:0]      rd_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [12:0]     ctrl_q;

  logic rs1_used;
  logic rs2_used;
  logic hazard;
  logic xfer_in;
  logic xfer_out;

  assign rs1_used = !((in_bus.opcode == OPC_LUI) || (in_bus.opcode == OPC_AUIPC) ||
                      (in_bus.opcode == OPC_JAL));
  assign rs2_used = (in_bus.opcode == OPC_OP) || (in_bus.opcode == OPC_STORE) ||
                    (in_bus.opcode == OPC_BRANCH);

  assign hazard = valid_q && ctrl_q[C_MRD] && (rd_q != 5'd0) &&
                  ((rs1_used && (in_bus.rs1 == rd_q)) || (rs2_used && (in_bus.rs2 == rd_q)));

  assign in_bus.ready = flush || ((!valid_q || out_bus.ready) && !hazard);
  assign xfer_in      = in_bus.valid && in_bus.ready;
  assign xfer_out     = valid_q && out_bus.ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      ctrl_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (xfer_in) begin
      valid_q    <= 1'b1;
      opcode_q   <= in_bus.opcode;
      rd_q       <= in_bus.rd;
      rs1_q      <= in_bus.rs1;
      rs2_q      <= in_bus.rs2;
      funct3_q   <= in_bus.funct3;
      funct7_q   <= in_bus.funct7;
      pc_q       <= in_bus.pc;
      rs1_data_q <= in_bus.rs1_data;
      rs2_data_q <= in_bus.rs2_data;
      imm_q      <= in_bus.imm;
      ctrl_q     <= in_bus.ctrl;
    end else if (xfer_out) begin
      valid_q <= 1'b0;
    end
  end

  // Side-effecting controls are forced inert while nothing valid is held
  logic [12:0] ctrl_gated;
  always_comb begin
    ctrl_gated = ctrl_q;
    if (!valid_q) begin
      ctrl_gated[C_WR]   = 1'b0;
      ctrl_gated[C_BR]   = 1'b0;
      ctrl_gated[C_JAL]  = 1'b0;
      ctrl_gated[C_JALR] = 1'b0;
      ctrl_gated[C_MRD]  = 1'b0;
      ctrl_gated[C_MWR]  = 1'b0;
      ctrl_gated[3:0]    = ALU_SELECT_NOP;
    end
  end

  assign out_bus.valid    = valid_q;
  assign out_bus.opcode   = opcode_q;
  assign out_bus.rd       = rd_q;
  assign out_bus.rs1      = rs1_q;
  assign out_bus.rs2      = rs2_q;
  assign out_bus.funct3   = funct3_q;
  assign out_bus.funct7   = funct7_q;
  assign out_bus.pc       = pc_q;
  assign out_bus.rs1_data = rs1_data_q;
  assign out_bus.rs2_data = rs2_data_q;
  assign out_bus.imm      = imm_q;
  assign out_bus.ctrl     = ctrl_gated;

  assign out_regfile_wr_en = ctrl_gated[C_WR];
  assign out_is_branch     = ctrl_gated[C_BR];
  assign out_is_jal        = ctrl_gated[C_JAL];
  assign out_is_jalr       = ctrl_gated[C_JALR];
  assign out_mem_rd_en     = ctrl_gated[C_MRD];
  assign out_mem_wr_en     = ctrl_gated[C_MWR];
  assign out_alu_select    = ctrl_gated[3:0];

`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (in_bus.valid && hazard && !flush && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: streaming, load-use bubble, hold, flush, reset, saturation.
module tb_id_ex_register;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [3:0] NOP        = 4'hF;

  logic clk;
  logic reset_n;
  logic flush;
  logic out_regfile_wr_en, out_is_branch, out_is_jal, out_is_jalr;
  logic out_mem_rd_en, out_mem_wr_en;
  logic [3:0] out_alu_select;
  logic [31:0] stall_cycles;
  int total;
  int bad;

  id_ex_register_if #(.XLEN(32)) dec_if ();
  id_ex_register_if #(.XLEN(32)) ex_if ();

  id_ex_register #(.XLEN(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .flush             (flush),
    .in_bus            (dec_if),
    .out_bus           (ex_if),
    .out_regfile_wr_en (out_regfile_wr_en),
    .out_is_branch     (out_is_branch),
    .out_is_jal        (out_is_jal),
    .out_is_jalr       (out_is_jalr),
    .out_mem_rd_en     (out_mem_rd_en),
    .out_mem_wr_en     (out_mem_wr_en),
    .out_alu_select    (out_alu_select)
`ifdef ID_EX_STALL_COUNT_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

`ifndef ID_EX_STALL_COUNT_EN
  assign stall_cycles = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic rsv, input logic wr, input logic br,
                                     input logic jal, input logic jalr, input logic mds,
                                     input logic mrd, input logic mwr, input logic rsb,
                                     input logic [3:0] alu);
    return {rsv, wr, br, jal, jalr, mds, mrd, mwr, rsb, alu};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [12:0] ctrl);
    dec_if.valid    = v;
    dec_if.opcode   = opc;
    dec_if.rd       = rd;
    dec_if.rs1      = rs1;
    dec_if.rs2      = rs2;
    dec_if.funct3   = rd[2:0];
    dec_if.funct7   = {2'b00, rs2};
    dec_if.pc       = pc;
    dec_if.rs1_data = 32'hA000_0000 | pc;
    dec_if.rs2_data = 32'hB000_0000 | pc;
    dec_if.imm      = imm;
    dec_if.ctrl     = ctrl;
  endtask

  task automatic idle();
    dec_if.valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [12:0] c_addi, c_lw, c_add, c_sw, c_beq, c_jal, c_lui;

  initial begin
    total = 0;
    bad   = 0;
    c_addi = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    c_lw   = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
    c_add  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    c_sw   = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    c_beq  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
    c_jal  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    c_lui  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);

    reset_n     = 1'b0;
    flush       = 1'b0;
    ex_if.ready = 1'b1;
    drive(1'b0, OPC_OP_IMM, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 13'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(ex_if.valid), 32'd0);
    check("rst_pc", ex_if.pc, 32'd0);
    check("rst_imm", ex_if.imm, 32'd0);
    check("rst_wr_en", 32'(out_regfile_wr_en), 32'd0);
    check("rst_alu", 32'(out_alu_select), 32'(NOP));
    check("rst_ctrl", 32'(ex_if.ctrl), 32'h000F);
    check("rst_stall", stall_cycles, 32'd0);

    // addi x1..x4 back to back
    for (int i = 1; i <= 4; i++) begin
      cyc();
      drive(1'b1, OPC_OP_IMM, 5'(i), 5'd0, 5'd0, 32'h100 + 32'(4 * (i - 1)), 32'(i), c_addi);
      @(negedge clk);
      check("stream_in_ready", 32'(dec_if.ready), 32'd1);
      if (i > 1) begin
        check("stream_valid", 32'(ex_if.valid), 32'd1);
        check("stream_pc", ex_if.pc, 32'h100 + 32'(4 * (i - 2)));
        check("stream_rd", 32'(ex_if.rd), 32'(i - 1));
      end
    end
    cyc();
    idle();
    @(negedge clk);
    check("stream_last_valid", 32'(ex_if.valid), 32'd1);
    check("stream_last_pc", ex_if.pc, 32'h10C);
    check("stream_last_rd", 32'(ex_if.rd), 32'd4);
    check("stream_last_imm", ex_if.imm, 32'd4);
    check("stream_rs1_data", ex_if.rs1_data, 32'hA000_010C);
    check("stream_rs2_data", ex_if.rs2_data, 32'hB000_010C);
    check("stream_funct3", 32'(ex_if.funct3), 32'd4);
    check("stream_wr_en", 32'(out_regfile_wr_en), 32'd1);
    cyc();
    @(negedge clk);
    check("drain_valid", 32'(ex_if.valid), 32'd0);
    check("drain_alu_nop", 32'(out_alu_select), 32'(NOP));
    check("drain_pc_kept", ex_if.pc, 32'h10C);

    // lw x5,0(x2) ; add x6,x5,x1 -> one bubble
    cyc();
    drive(1'b1, OPC_LOAD, 5'd5, 5'd2, 5'd0, 32'h200, 32'd0, c_lw);
    @(negedge clk);
    check("lu_lw_ready", 32'(dec_if.ready), 32'd1);
    cyc();
    drive(1'b1, OPC_OP, 5'd6, 5'd5, 5'd1, 32'h204, 32'd0, c_add);
    @(negedge clk);
    check("lu_lw_out", 32'(ex_if.rd), 32'd5);
    check("lu_mem_rd_en", 32'(out_mem_rd_en), 32'd1);
    check("lu_blocked", 32'(dec_if.ready), 32'd0);
    cyc();
    @(negedge clk);
    check("lu_bubble", 32'(ex_if.valid), 32'd0);
    check("lu_bubble_wr", 32'(out_regfile_wr_en), 32'd0);
    check("lu_accept", 32'(dec_if.ready), 32'd1);
    cyc();
    idle();
    @(negedge clk);
    check("lu_add_valid", 32'(ex_if.valid), 32'd1);
    check("lu_add_rd", 32'(ex_if.rd), 32'd6);
`ifdef ID_EX_STALL_COUNT_EN
    check("lu_stall_cnt", stall_cycles, 32'd1);
`endif

    // lw x0 ; add x6,x0,x1 -> no stall
    cyc();
    drive(1'b1, OPC_LOAD, 5'd0, 5'd2, 5'd0, 32'h300, 32'd0, c_lw);
    cyc();
    drive(1'b1, OPC_OP, 5'd6, 5'd0, 5'd1, 32'h304, 32'd0, c_add);
    @(negedge clk);
    check("x0_ready", 32'(dec_if.ready), 32'd1);
    cyc();
    drive(1'b1, OPC_LOAD, 5'd5, 5'd2, 5'd0, 32'h308, 32'd0, c_lw);
    @(negedge clk);
    check("x0_add_valid", 32'(ex_if.valid), 32'd1);
    check("x0_add_pc", ex_if.pc, 32'h304);
    // lui x5 carries rs1=5 in its field but does not read it
    cyc();
    drive(1'b1, OPC_LUI, 5'd5, 5'd5, 5'd5, 32'h30C, 32'h1234_5000, c_lui);
    @(negedge clk);
    check("lui_ready", 32'(dec_if.ready), 32'd1);
    cyc();
    idle();
    @(negedge clk);
    check("lui_out_pc", ex_if.pc, 32'h30C);
    check("lui_out_imm", ex_if.imm, 32'h1234_5000);
`ifdef ID_EX_STALL_COUNT_EN
    check("nostall_cnt", stall_cycles, 32'd1);
`endif
    cyc();

    // hold sw for 3 cycles with addi x7 waiting
    drive(1'b1, OPC_STORE, 5'd0, 5'd2, 5'd3, 32'h400, 32'd8, c_sw);
    cyc();
    ex_if.ready = 1'b0;
    drive(1'b1, OPC_OP_IMM, 5'd7, 5'd1, 5'd0, 32'h404, 32'd7, c_addi);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(ex_if.valid), 32'd1);
      check("hold_pc", ex_if.pc, 32'h400);
      check("hold_mem_wr", 32'(out_mem_wr_en), 32'd1);
      check("hold_rsv_bit", 32'(ex_if.ctrl[12]), 32'd1);
      check("hold_in_ready", 32'(dec_if.ready), 32'd0);
      cyc();
    end
    ex_if.ready = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(dec_if.ready), 32'd1);
    check("release_store_out", 32'(ex_if.opcode), 32'(OPC_STORE));
    cyc();
    idle();
    @(negedge clk);
    check("release_next_rd", 32'(ex_if.rd), 32'd7);
    check("release_next_pc", ex_if.pc, 32'h404);

    // flush while holding beq with jal incoming
    cyc();
    drive(1'b1, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 32'h500, 32'h10, c_beq);
    cyc();
    ex_if.ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, OPC_JAL, 5'd1, 5'd0, 5'd0, 32'h504, 32'h40, c_jal);
    @(negedge clk);
    check("flush_held_branch", 32'(out_is_branch), 32'd1);
    check("flush_ready", 32'(dec_if.ready), 32'd1);
    cyc();
    flush = 1'b0;
    idle();
    ex_if.ready = 1'b1;
    @(negedge clk);
    check("flush_valid", 32'(ex_if.valid), 32'd0);
    check("flush_wr_en", 32'(out_regfile_wr_en), 32'd0);
    check("flush_alu_nop", 32'(out_alu_select), 32'(NOP));
    check("flush_is_jal", 32'(out_is_jal), 32'd0);
    check("flush_no_capture", 32'(ex_if.opcode), 32'(OPC_BRANCH));
    cyc();
    @(negedge clk);
    check("flush_jal_absent", 32'(ex_if.valid), 32'd0);

    // flush together with a hazard: flush wins, no stall counted
    drive(1'b1, OPC_LOAD, 5'd5, 5'd2, 5'd0, 32'h600, 32'd0, c_lw);
    cyc();
    ex_if.ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, OPC_OP, 5'd6, 5'd5, 5'd1, 32'h604, 32'd0, c_add);
    @(negedge clk);
    check("flushhaz_ready", 32'(dec_if.ready), 32'd1);
    cyc();
    flush = 1'b0;
    idle();
    ex_if.ready = 1'b1;
    @(negedge clk);
    check("flushhaz_valid", 32'(ex_if.valid), 32'd0);
`ifdef ID_EX_STALL_COUNT_EN
    check("flushhaz_cnt", stall_cycles, 32'd1);

    // saturation with a held load and a waiting dependent
    drive(1'b1, OPC_LOAD, 5'd5, 5'd2, 5'd0, 32'h700, 32'd0, c_lw);
    cyc();
    ex_if.ready = 1'b0;
    drive(1'b1, OPC_OP, 5'd6, 5'd1, 5'd5, 32'h704, 32'd0, c_add);
    force dut.stall_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_q;
    repeat (3) cyc();
    @(negedge clk);
    check("sat_ready", 32'(dec_if.ready), 32'd0);
    check("sat_cnt", stall_cycles, 32'hFFFF_FFFF);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    idle();
    ex_if.ready = 1'b1;
`endif

    // reset mid-stream
    cyc();
    drive(1'b1, OPC_OP_IMM, 5'd9, 5'd0, 5'd0, 32'h800, 32'd9, c_addi);
    cyc();
    reset_n = 1'b0;
    drive(1'b1, OPC_OP_IMM, 5'd10, 5'd0, 5'd0, 32'h804, 32'd10, c_addi);
    @(negedge clk);
    check("prerst_valid", 32'(ex_if.valid), 32'd1);
    cyc();
    reset_n = 1'b1;
    idle();
    @(negedge clk);
    check("midrst_valid", 32'(ex_if.valid), 32'd0);
    check("midrst_pc", ex_if.pc, 32'd0);
    check("midrst_rd", 32'(ex_if.rd), 32'd0);
    check("midrst_rs1_data", ex_if.rs1_data, 32'd0);
    check("midrst_alu", 32'(out_alu_select), 32'(NOP));
    check("midrst_stall", stall_cycles, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_register.md
# id_ex_register

Pipeline register between the decode stage (instruction fields, register-file read data and the opcode-derived control bundle) and the execute stage. It holds one decoded instruction behind a valid/ready handshake and detects load-use hazards against the instruction it holds, inserting exactly one bubble when needed. It also accepts a flush from branch/jump resolution in execute. All control outputs are gated so execute can consume them without re-qualifying on `out_valid`.

## Interface
- `XLEN`, 32, datapath width for pc, operands, immediate
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  synchronous, active-low reset
- `flush`  in  1  kill held entry and any incoming beat this cycle
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  register accepts this cycle
- `in_opcode`  in  7  instruction opcode (ISA opcode macros)
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices
- `in_funct3`  in  3, `in_funct7`  in  7  function fields
- `in_pc`, `in_rs1_data`, `in_rs2_data`, `in_imm`  in  XLEN each  operands
- `in_ctrl`  in  13  {regfile_wr_en, is_branch, is_jal, is_jalr, mem_data_select, mem_rd_en, mem_wr_en, reg_select_b, alu_select[3:0]}; the 13th bit is reserved, always captured and passed through
- `out_valid`  out  1  held entry valid for execute
- `out_ready`  in  1  execute consumes this cycle
- `out_*`  out  registered copies of every `in_*` field above, same widths
- `stall_cycles`  out  32  present only with the configuration macro

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- rs1 use: every opcode except LUI, AUIPC, JAL. rs2 use: ALU, STORE, BRANCH.
- Hazard: `out_valid && held mem_rd_en && held rd != 0 && ((rs1 used && in_rs1 == held rd) || (rs2 used && in_rs2 == held rd))`.
- `in_ready = flush || ((!out_valid || out_ready) && !hazard)`.
- Priority per edge: reset > flush > capture > drain > hold.
  - Flush: `out_valid` <= 0; any incoming beat is accepted and discarded.
  - Capture: on transfer in, all fields are registered and `out_valid` <= 1.
  - Drain: transfer out with no transfer in; `out_valid` <= 0.
  - Hold: `out_valid && !out_ready`; all outputs stable.
- Load-use sequence: the load drains while the dependent is blocked. The next cycle is a bubble (`out_valid` = 0). The dependent is accepted the cycle after that. Exactly one bubble per hazard.
- Gating: while `out_valid` = 0, `out_regfile_wr_en`, `out_mem_rd_en`, `out_mem_wr_en`, `out_is_branch`, `out_is_jal`, `out_is_jalr` read 0 and `out_alu_select` reads `ALU_SELECT_NOP`. Data fields retain their last value.
- Reset: `out_valid` = 0, all data fields 0, control fields as gated above, `stall_cycles` = 0.

## Timing
- Latency: 1 cycle from transfer in to `out_valid`.
- `in_ready` is combinational from `flush`, `out_ready`, held state and `in_opcode`/`in_rs1`/`in_rs2`. All `out_*` are registered.
- Back-to-back: with `out_ready` held high, one instruction per cycle, no bubbles except hazards.
- Hazard released: a held load that has not yet drained keeps `in_ready` low indefinitely. `flush` clears the hazard in the same cycle.
- Simultaneous flush and hazard: flush wins; no bubble is counted.
- Reset mid-transfer: the in-flight entry is discarded. Upstream must treat a beat presented during reset as not accepted.

## Configuration
- `ID_EX_STALL_COUNT_EN` defined: `stall_cycles` port exists. It increments by 1 each cycle with `in_valid && hazard && !flush` and saturates at 0xFFFF_FFFF. Reset clears it.
- Not defined: port and counter are absent. Handshake and hazard behaviour are identical.

## Test plan
- Stream `addi x1..x4` with `out_ready`=1 -> 4 outputs on 4 consecutive cycles, 1 cycle after each accept, pc values preserved.
- `lw x5,0(x2)` then `add x6,x5,x1` -> `in_ready`=0 for one cycle, `out_valid`=0 for exactly one cycle between them, `stall_cycles` = 1.
- `lw x0,0(x2)` then `add x6,x0,x1`, and `lw x5` then `lui x5,0x12345` -> no stall, no bubble.
- Hold with `out_ready`=0 for 3 cycles while holding `sw`, `in_valid`=1 -> outputs stable, `in_ready`=0. Release -> store exits, next instruction appears the following cycle.
- `flush`=1 while holding `beq` and `in_valid`=1 with `jal` -> next cycle `out_valid`=0, `out_regfile_wr_en`=0, `out_alu_select`=NOP, `jal` never appears.
- Drive `reset_n`=0 mid-stream for 1 cycle -> next edge `out_valid`=0, all data 0, `stall_cycles`=0. Force the counter near max and hold a hazard -> counter stays at 0xFFFF_FFFF.
